// File: rtl/regfile_sb.sv
// regfile_sb: RISC-V integer register file, two combinational read ports,
// one synchronous write port, per-register pending-write scoreboard.
// x0 reads as zero, ignores writes and is never marked busy.
// Compile-time option: REGFILE_SB_BYPASS_EN forwards the write port to the
// read ports in the same cycle (data and busy bit).
module regfile_sb #(
   parameter int unsigned n  = 32,
   parameter int unsigned aw = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            regw,
   input  logic [aw-1:0]   waddr,
   input  logic [n-1:0]    wdata,
   input  logic [aw-1:0]   rR1,
   input  logic [aw-1:0]   rR2,
   output logic [n-1:0]    dR1,
   output logic [n-1:0]    dR2,
   output logic            busy1,
   output logic            busy2,
   input  logic            resv,
   input  logic [aw-1:0]   raddr,
   output logic            resv_err,
   output logic [aw:0]     nbusy
);

   localparam int unsigned NREG = 2**aw;
   localparam int unsigned CW   = aw + 1;

   logic [n-1:0]    r_mem [NREG];
   logic [NREG-1:0] r_busy;
   logic [CW-1:0]   r_nbusy;
   logic            r_resv_err;

   logic            w_wr_ok;
   logic            w_rs_ok;
   logic            w_set;
   logic            w_err;
   logic            w_clr;
   logic [NREG-1:0] w_busy_nxt;

   // Qualify requests: anything aimed at x0 is dropped.
   always_comb begin
      w_wr_ok = regw && (waddr != '0);
      w_rs_ok = resv && (raddr != '0);
      w_set   = w_rs_ok && !r_busy[raddr];
      w_err   = w_rs_ok &&  r_busy[raddr];
      // A write clears its busy bit unless a same-address reserve re-arms it.
      w_clr   = w_wr_ok && r_busy[waddr] && !(w_rs_ok && (raddr == waddr));
   end

   // Next busy vector: write clears first, reservation wins on a collision.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_ok) w_busy_nxt[waddr] = 1'b0;
      if (w_rs_ok) w_busy_nxt[raddr] = 1'b1;
   end

   // Storage, scoreboard, busy counter and reserve-error flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) r_mem[i] <= '0;
         r_busy     <= '0;
         r_nbusy    <= '0;
         r_resv_err <= 1'b0;
      end else begin
         if (w_wr_ok) r_mem[waddr] <= wdata;
         r_busy     <= w_busy_nxt;
         r_nbusy    <= r_nbusy + CW'(w_set) - CW'(w_clr);
         r_resv_err <= w_err;
      end
   end

   // Read ports, with optional same-cycle forwarding from the write port.
   always_comb begin
      dR1   = (rR1 == '0) ? '0 : r_mem[rR1];
      dR2   = (rR2 == '0) ? '0 : r_mem[rR2];
      busy1 = (rR1 == '0) ? 1'b0 : r_busy[rR1];
      busy2 = (rR2 == '0) ? 1'b0 : r_busy[rR2];
`ifdef REGFILE_SB_BYPASS_EN
      if (w_wr_ok && (waddr == rR1)) begin
         dR1   = wdata;
         busy1 = w_rs_ok && (raddr == waddr);
      end
      if (w_wr_ok && (waddr == rR2)) begin
         dR2   = wdata;
         busy2 = w_rs_ok && (raddr == waddr);
      end
`endif
   end

   assign resv_err = r_resv_err;
   assign nbusy    = r_nbusy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; expectations adapt to REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;

   logic        clock = 1'b0;
   logic        reset, regw, resv;
   logic [4:0]  waddr, rR1, rR2, raddr;
   logic [31:0] wdata, dR1, dR2;
   logic        busy1, busy2, resv_err;
   logic [5:0]  nbusy;

   int n_cmp = 0;
   int n_err = 0;

   regfile_sb #(.n(32), .aw(5)) dut (
      .clock(clock), .reset(reset), .regw(regw), .waddr(waddr), .wdata(wdata),
      .rR1(rR1), .rR2(rR2), .dR1(dR1), .dR2(dR2), .busy1(busy1), .busy2(busy2),
      .resv(resv), .raddr(raddr), .resv_err(resv_err), .nbusy(nbusy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      regw = 1'b0; resv = 1'b0; reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; regw = 1'b0; resv = 1'b0;
      waddr = '0; wdata = '0; rR1 = '0; rR2 = '0; raddr = '0;
      tick();
      idle();

      // Populate x3 and reserve x4, then reset with both ports active.
      regw = 1'b1; waddr = 5'd3; wdata = 32'd99; resv = 1'b1; raddr = 5'd4;
      tick();
      idle(); rR1 = 5'd3; rR2 = 5'd4; #1;
      check("pre_reset_x3", dR1, 32'd99);
      check("pre_reset_nbusy", 32'(nbusy), 32'd1);
      reset = 1'b1; regw = 1'b1; waddr = 5'd3; wdata = 32'd7; resv = 1'b1; raddr = 5'd4;
      tick();
      idle(); #1;
      check("rst_x3", dR1, 32'd0);
      check("rst_busy_x4", 32'(busy2), 32'd0);
      check("rst_nbusy", 32'(nbusy), 32'd0);
      check("rst_resv_err", 32'(resv_err), 32'd0);

      // Plain writes; a later cycle with regw=0 must not write.
      regw = 1'b1; waddr = 5'd28; wdata = 32'd10; tick();
      waddr = 5'd29; wdata = 32'd5000; tick();
      regw = 1'b0; waddr = 5'd28; wdata = 32'd502; rR1 = 5'd29; rR2 = 5'd28; #1;
      check("rd_x29", dR1, 32'd5000);
      check("rd_x28", dR2, 32'd10);
      tick();
      check("rd_x28_nowrite", dR2, 32'd10);

      // x0: write and reserve both ignored.
      regw = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; resv = 1'b1; raddr = 5'd0; rR1 = 5'd0;
      tick();
      idle(); #1;
      check("x0_data", dR1, 32'd0);
      check("x0_busy", 32'(busy1), 32'd0);
      check("x0_nbusy", 32'(nbusy), 32'd0);
      check("x0_err", 32'(resv_err), 32'd0);

      // Reserve x5, double reserve, then write back.
      resv = 1'b1; raddr = 5'd5; rR1 = 5'd5; #1;
      check("x5_busy_before_edge", 32'(busy1), 32'd0);
      tick();
      idle(); #1;
      check("x5_busy", 32'(busy1), 32'd1);
      check("x5_nbusy", 32'(nbusy), 32'd1);
      check("x5_err0", 32'(resv_err), 32'd0);
      resv = 1'b1; tick(); idle(); #1;
      check("x5_err1", 32'(resv_err), 32'd1);
      check("x5_nbusy_dup", 32'(nbusy), 32'd1);
      tick();
      check("x5_err_pulse", 32'(resv_err), 32'd0);
      regw = 1'b1; waddr = 5'd5; wdata = 32'd7; #1;
`ifdef REGFILE_SB_BYPASS_EN
      check("x5_busy_fwd", 32'(busy1), 32'd0);
`else
      check("x5_busy_nofwd", 32'(busy1), 32'd1);
`endif
      tick();
      idle(); #1;
      check("x5_busy_clr", 32'(busy1), 32'd0);
      check("x5_nbusy_clr", 32'(nbusy), 32'd0);
      check("x5_data", dR1, 32'd7);

      // Same-cycle write/read of x7.
      regw = 1'b1; waddr = 5'd7; wdata = 32'h1234; rR1 = 5'd7; #1;
`ifdef REGFILE_SB_BYPASS_EN
      check("x7_same_cycle", dR1, 32'h1234);
`else
      check("x7_same_cycle", dR1, 32'h0);
`endif
      tick();
      idle(); #1;
      check("x7_next_cycle", dR1, 32'h1234);

      // Reserve and write x9 together: data lands, reservation stays.
      resv = 1'b1; raddr = 5'd9; regw = 1'b1; waddr = 5'd9; wdata = 32'd55; rR2 = 5'd9; #1;
`ifdef REGFILE_SB_BYPASS_EN
      check("x9_busy_fwd", 32'(busy2), 32'd1);
`endif
      tick();
      idle(); #1;
      check("x9_data", dR2, 32'd55);
      check("x9_busy", 32'(busy2), 32'd1);
      check("x9_nbusy", 32'(nbusy), 32'd1);
      check("x9_err", 32'(resv_err), 32'd0);

      // Reserve x10 while writing back x9: +1 -1.
      resv = 1'b1; raddr = 5'd10; regw = 1'b1; waddr = 5'd9; wdata = 32'd66; rR1 = 5'd10;
      tick();
      idle(); #1;
      check("mix_nbusy", 32'(nbusy), 32'd1);
      check("mix_busy_x10", 32'(busy1), 32'd1);
      check("mix_busy_x9", 32'(busy2), 32'd0);
      check("mix_data_x9", dR2, 32'd66);

      // Reserve and write x10 while x10 already busy: error, count unchanged.
      resv = 1'b1; raddr = 5'd10; regw = 1'b1; waddr = 5'd10; wdata = 32'd77;
      tick();
      idle(); #1;
      check("dup_err", 32'(resv_err), 32'd1);
      check("dup_nbusy", 32'(nbusy), 32'd1);
      check("dup_busy", 32'(busy1), 32'd1);
      check("dup_data", dR1, 32'd77);

      // Fill the scoreboard to its maximum, then drain it.
      for (int i = 1; i < 32; i++) begin
         resv = 1'b1; raddr = 5'(i); tick();
      end
      idle(); #1;
      check("full_nbusy", 32'(nbusy), 32'd31);
      check("full_err_last", 32'(resv_err), 32'd0);
      for (int i = 1; i < 32; i++) begin
         regw = 1'b1; waddr = 5'(i); wdata = 32'(i * 3); tick();
      end
      idle(); rR1 = 5'd31; rR2 = 5'd10; #1;
      check("drain_nbusy", 32'(nbusy), 32'd0);
      check("drain_x31", dR1, 32'd93);
      check("drain_busy_x10", 32'(busy2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised RISC-V integer register file with two combinational read ports, one synchronous write port, and a per-register pending-write scoreboard. Sits in the decode stage. Read ports feed operand muxes. The scoreboard lets the hazard unit stall on operands whose multi-cycle producer (load, divide) has not yet written back. x0 is hardwired to zero. Optional write-to-read forwarding is selected at compile time.

## Interface
- n, 32: data width in bits
- aw, 5: register address width; register count is 2**aw

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- regw  in  1  write enable
- waddr  in  aw  write address
- wdata  in  n  write data
- rR1  in  aw  read address, port 1
- rR2  in  aw  read address, port 2
- dR1  out  n  read data, port 1 (combinational)
- dR2  out  n  read data, port 2 (combinational)
- busy1  out  1  pending-write bit for rR1 (combinational)
- busy2  out  1  pending-write bit for rR2 (combinational)
- resv  in  1  reserve request: mark raddr pending
- raddr  in  aw  address to reserve
- resv_err  out  1  registered; previous-cycle reserve hit an already-busy register
- nbusy  out  aw+1  registered count of busy registers

## Operation
- Storage: 2**aw entries of n bits, plus a busy bit per entry.
- Register 0:
  - reads return 0;
  - writes to it are dropped;
  - its busy bit is never set;
  - a reserve to address 0 is a no-op with no error.
- Write: when regw=1 and waddr!=0, mem[waddr] <= wdata and busy[waddr] <= 0 at the clock edge.
- Reserve: when resv=1 and raddr!=0:
  - busy[raddr] <= 1;
  - if busy[raddr] was already 1, resv_err <= 1 for one cycle and nbusy is unchanged.
- Otherwise resv_err <= 0.
- Reserve and write to the same address in the same cycle:
  - data is written and busy ends at 1 (reservation wins);
  - no error unless the bit was already set before the edge;
  - nbusy is net unchanged if the bit was already set, and +1 otherwise.
- Reserve and write to different addresses in the same cycle: both apply independently; nbusy changes by (+1 if new set) + (-1 if a busy bit cleared).
- nbusy always equals the popcount of the busy bits. Its maximum is 2**aw - 1, so it never wraps.
- Reads: dRk = mem[rRk] and busyk = busy[rRk], with address 0 forced to data 0 and busy 0.
- Reset:
  - every register, every busy bit, nbusy and resv_err go to 0 on the next edge;
  - reset dominates regw and resv asserted in the same cycle.

## Timing
- Write latency: 1 edge. Without forwarding, the new value is visible on dRk the cycle after the write.
- busyk rises the cycle after the reserve edge.
- busyk falls the cycle after the write edge, or in the same cycle when forwarding is compiled in.
- resv_err and nbusy update 1 edge after the causing request.
- dR1, dR2, busy1 and busy2 are purely combinational from the read addresses and state (plus the write port when forwarding is on).
- Reset values: dR1=dR2=0, busy1=busy2=0, resv_err=0, nbusy=0.

## Configuration
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: when regw=1 and waddr==rRk!=0, in the same cycle:
  - dRk = wdata;
  - busyk = 0, unless resv=1 with raddr==waddr, in which case busyk = 1.
- Undefined: no forwarding. dRk and busyk reflect stored state only, and the written value appears on the next cycle.

## Test plan
- Reset with regw=1, waddr=3, wdata=7 held in the same cycle -> next cycle, a read of x3 gives 0, nbusy=0, resv_err=0.
- Write x28=10, then x29=5000; then regw=0, waddr=28, wdata=502; read rR1=29, rR2=28 -> dR1=5000, dR2=10.
- Write x0=32'hDEADBEEF with rR1=0; reserve raddr=0 -> dR1=0, busy1=0, nbusy=0, resv_err=0.
- Reserve x5 -> busy1=1 for rR1=5, nbusy=1. Reserve x5 again -> resv_err=1 for one cycle, nbusy=1. Write x5=7 -> busy1=0, nbusy=0, dR1=7.
- Same cycle: regw with waddr=7, wdata=32'h1234 and rR1=7 (x7 previously 0) -> with the macro, dR1=32'h1234 in that cycle; without it, dR1=0 then 32'h1234 the next cycle.
- Same cycle: resv and regw both to x9, x9 not previously busy -> next cycle, dR2 shows the new data, busy2=1, nbusy=1, resv_err=0.
